line_cmd_scheduler: RTL and testbench
=====================================

Name: line_cmd_scheduler

Overview:
- Accepts line-endpoint commands (x0, y0, x1, y1) from NUM_REQ independent requesters.
- A round-robin arbiter admits them into a small command FIFO.
- At frame boundaries the block sequences them into the single line_drawer datapath, holding each line's coordinates stable for HOLD_FRAMES frames.
- It sits between control sources (switch/UART decoders) and line_drawer, in the vga_clk domain.

Parameters:
- NUM_REQ, 2: number of requesters, 2..4.
- DEPTH, 4: command FIFO entries, power of two.
- HOLD_FRAMES, 2: frames each line is displayed before the next queued line may replace it, 1..15.
- VSYNC_POL, 0: active level of vsync (0 = active-low).

Ports:
- clk  in  1  pixel clock (vga_clk).
- rst  in  1  reset, synchronous, active-high.
- vsync  in  1  vertical sync from vga_controller.
- req_valid  in  NUM_REQ  per-requester command valid.
- req_ready  out  NUM_REQ  per-requester accept; a transfer occurs when valid && ready.
- req_cmd  in  NUM_REQ*48  per-requester {x0,y0,x1,y1}, 12 b each, x0 in MSBs, requester 0 in the LSB slice.
- drw_x0, drw_y0, drw_x1, drw_y1  out  12 each  coordinates driven to line_drawer.
- drw_load  out  1  one-cycle pulse when the drw_* outputs change.
- line_valid  out  1  a line has been loaded since reset/flush.
- flush  in  1  discard queued commands and blank the line.
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overrun  out  1  sticky; set when the FIFO is full while any req_valid is high.

Behaviour:
- Reset (rst=1 at a clk edge):
  - FIFO empty; fifo_count=0.
  - drw_*=0; drw_load=0; line_valid=0; overrun=0.
  - req_ready=0; round-robin pointer=0; hold counter=0; FSM=IDLE.
  - Reset mid-transfer drops any in-flight command.
- Arbiter:
  - Combinational grant over req_valid, starting search at the pointer.
  - At most one accept per cycle.
  - req_ready[i]=1 only for the granted i, and only when the FIFO is not full (or a pop occurs in the same cycle).
  - Pointer advances to grant+1 (mod NUM_REQ) only on an accepted transfer.
- FIFO:
  - Synchronous; write on accept, read on pop.
  - A simultaneous push and pop at full is legal; count is unchanged.
  - A push when full is impossible (ready=0).
  - overrun sets when count==DEPTH && |req_valid; it is cleared only by rst.
- Frame tick:
  - vs_act = (vsync == VSYNC_POL), registered once.
  - frame_tick = one-cycle pulse on the inactive→active transition of vs_act.
- FSM:
  - IDLE: on frame_tick with FIFO non-empty → pop, load drw_*, pulse drw_load next cycle, line_valid=1, hold counter=HOLD_FRAMES-1, go to SHOW.
  - SHOW: each frame_tick decrements the hold counter while it is >0. When the counter==0 and a frame_tick occurs:
    - FIFO non-empty → pop/load as above, stay in SHOW.
    - FIFO empty → retain the current line, stay in SHOW (counter stays 0, so the next command loads on the first frame_tick after it arrives).
  - drw_* change only on a frame_tick cycle; this is the no-tearing guarantee.
  - Load latency: drw_* update on the clock edge after the frame_tick cycle; drw_load is high for exactly that one cycle after the update.
- flush:
  - Has priority over everything except rst.
  - Empties the FIFO; drw_*=0; line_valid=0; FSM=IDLE; hold counter=0.
  - req_ready=0 during the flush cycle.
  - Does not clear overrun.
- Arithmetic: coordinates pass through unmodified; no clipping. Hold counter is 4 b; count/pointer wrap modulo width.

Test Plan:
1. Reset then idle: rst high 3 cycles, no req → all outputs 0, fifo_count=0, no drw_load over 3 frames.
2. Single command: req0 sends {320,20,250,170} → accepted in 1 cycle, fifo_count=1. Next vsync falling edge (VSYNC_POL=0): drw_*={320,20,250,170} one cycle after frame_tick, drw_load pulses once, line_valid=1.
3. Round-robin fairness: req0 and req1 both valid continuously, with different cmds → accepts alternate 0,1,0,1. FIFO fills to 4, req_ready drops, and overrun=1.
4. Hold timing, HOLD_FRAMES=2, two cmds A and B queued → A loads at frame 1, B loads at frame 3, not frame 2. Line B is retained through frames 4–6 with an empty FIFO.
5. Simultaneous push/pop at full: FIFO=4, frame_tick with req1 valid → one pop and one push in the same cycle; fifo_count stays 4 and the order is preserved.
6. Flush and reset mid-operation: flush during SHOW with 3 queued → fifo_count=0, drw_*=0, line_valid=0, overrun unchanged. A new cmd then loads on the next frame_tick. A rst mid-accept leaves nothing queued.

Source files
------------

// File: rtl/line_cmd_scheduler.sv
// Round-robin admission of line commands into a FIFO, released to line_drawer on frame ticks.
// state | meaning -- IDLE: no line shown yet ; SHOW: a line is displayed, hold counter running
module line_cmd_scheduler #(
  parameter int NUM_REQ     = 2,
  parameter int DEPTH       = 4,
  parameter int HOLD_FRAMES = 2,
  parameter bit VSYNC_POL   = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      vsync,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*48-1:0]     req_cmd,
  output logic [11:0]               drw_x0,
  output logic [11:0]               drw_y0,
  output logic [11:0]               drw_x1,
  output logic [11:0]               drw_y1,
  output logic                      drw_load,
  output logic                      line_valid,
  input  logic                      flush,
  output logic [$clog2(DEPTH):0]    fifo_count,
  output logic                      overrun
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t          state_q, state_d;
  logic [3:0]      hold_q, hold_d;
  logic            vs_act_q, vs_act_qq, frame_tick;
  logic            pop, push, push_ok, full, empty;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [47:0]     mem [DEPTH];
  logic [47:0]     cmd_arr [NUM_REQ];
  logic [47:0]     wcmd;
  logic [PW-1:0]   rr_ptr, gnt_idx;
  logic            gnt_found;
  logic [PW:0]     idx;

  assign frame_tick = vs_act_q & ~vs_act_qq;
  assign full       = (fifo_count == CW'(DEPTH));
  assign empty      = (fifo_count == '0);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) cmd_arr[i] = req_cmd[i*48 +: 48];
  end

  // Search starts at the round-robin pointer and wraps once around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, rr_ptr} + (PW+1)'(k);
      if (idx >= (PW+1)'(NUM_REQ)) idx = idx - (PW+1)'(NUM_REQ);
      if (!gnt_found && req_valid[idx[PW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    pop     = 1'b0;
    if (flush) begin
      state_d = IDLE;
      hold_d  = '0;
    end else begin
      case (state_q)
        IDLE: if (frame_tick && !empty) begin
          pop     = 1'b1;
          state_d = SHOW;
          hold_d  = 4'(HOLD_FRAMES - 1);
        end
        SHOW: if (frame_tick) begin
          if (hold_q != '0) hold_d = hold_q - 4'd1;
          else if (!empty) begin
            pop    = 1'b1;
            hold_d = 4'(HOLD_FRAMES - 1);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // A pop in the same cycle frees a slot, so a full FIFO may still accept.
  assign push_ok   = (!full || pop) && !flush && !rst;
  assign push      = gnt_found && push_ok;
  assign req_ready = push ? (NUM_REQ'(1) << gnt_idx) : '0;
  assign wcmd      = cmd_arr[gnt_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wcmd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_act_q   <= 1'b0;
      vs_act_qq  <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      rr_ptr     <= '0;
      {drw_x0, drw_y0, drw_x1, drw_y1} <= '0;
      drw_load   <= 1'b0;
      line_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      vs_act_q  <= (vsync == VSYNC_POL);
      vs_act_qq <= vs_act_q;
      overrun   <= overrun | (full & (|req_valid));
      drw_load  <= pop;
      if (flush) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fifo_count <= '0;
        {drw_x0, drw_y0, drw_x1, drw_y1} <= '0;
        line_valid <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          rr_ptr <= (gnt_idx == PW'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        end
        if (pop) begin
          {drw_x0, drw_y0, drw_x1, drw_y1} <= mem[rd_ptr];
          rd_ptr     <= rd_ptr + 1'b1;
          line_valid <= 1'b1;
        end
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

endmodule

// File: tb/tb_line_cmd_scheduler.sv
// Randomized bench for line_cmd_scheduler against a queue-based model of the scheduling rules.
module tb_line_cmd_scheduler;
  localparam int NR = 2;
  localparam int D  = 4;
  localparam int H  = 2;

  logic          clk = 1'b1;
  logic          rst, vsync, flush;
  logic [NR-1:0] req_valid, req_ready;
  logic [NR*48-1:0] req_cmd;
  logic [11:0]   drw_x0, drw_y0, drw_x1, drw_y1;
  logic          drw_load, line_valid, overrun;
  logic [$clog2(D):0] fifo_count;

  always #5 clk = ~clk;

  line_cmd_scheduler #(.NUM_REQ(NR), .DEPTH(D), .HOLD_FRAMES(H), .VSYNC_POL(1'b0)) dut (
    .clk(clk), .rst(rst), .vsync(vsync), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .drw_x0(drw_x0), .drw_y0(drw_y0), .drw_x1(drw_x1), .drw_y1(drw_y1),
    .drw_load(drw_load), .line_valid(line_valid), .flush(flush), .fifo_count(fifo_count),
    .overrun(overrun)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: queued commands, the line on screen and how many more frames it must stay.
  logic [47:0] q[$];
  logic [47:0] m_drw;
  bit  m_load, m_lv, m_ovr, m_show, act_q, act_qq, model_ok;
  int  m_hold, m_ptr;

  initial begin
    int fcnt, flen, p, gnt;
    bit tick, pop_ok, can;
    logic [NR-1:0] exp_ready;
    logic [47:0] c;
    fcnt = 0; flen = 20; model_ok = 0;
    q.delete(); m_drw = '0; m_load = 0; m_lv = 0; m_ovr = 0; m_show = 0;
    m_hold = 0; m_ptr = 0; act_q = 0; act_qq = 0;
    for (int cyc = 0; cyc < 8000; cyc++) begin
      rst   = (cyc < 3) || ($urandom_range(0, 599) == 0);
      flush = (cyc > 3) && ($urandom_range(0, 249) == 0);
      fcnt++;
      if (fcnt >= flen) begin
        fcnt = 0;
        flen = $urandom_range(8, 30);
      end
      vsync = (fcnt < 3) ? 1'b0 : 1'b1;
      case ((cyc / 500) % 4)
        0: p = 10;
        1: p = 90;
        2: p = 40;
        default: p = 3;
      endcase
      for (int i = 0; i < NR; i++) req_valid[i] = ($urandom_range(0, 99) < p);
      for (int i = 0; i < NR; i++) req_cmd[i*48 +: 48] = {$urandom(), $urandom()};
      if (cyc >= 3 && cyc < 40) begin
        req_valid = (cyc == 5) ? NR'(1) : '0;
        req_cmd[47:0] = {12'd320, 12'd20, 12'd250, 12'd170};
      end

      @(negedge clk);
      tick   = act_q && !act_qq;
      pop_ok = !rst && !flush && tick && (q.size() > 0) && (!m_show || m_hold == 0);
      gnt = -1;
      for (int k = 0; k < NR; k++)
        if (gnt < 0 && req_valid[(m_ptr + k) % NR]) gnt = (m_ptr + k) % NR;
      can = !rst && !flush && (gnt >= 0) && ((q.size() < D) || pop_ok);
      exp_ready = can ? (NR'(1) << gnt) : '0;
      check_val("req_ready", 64'(req_ready), 64'(exp_ready));
      if (model_ok) begin
        check_val("fifo_count", 64'(fifo_count), 64'(q.size()));
        check_val("drw", 64'({drw_x0, drw_y0, drw_x1, drw_y1}), 64'(m_drw));
        check_val("drw_load", 64'(drw_load), 64'(m_load));
        check_val("line_valid", 64'(line_valid), 64'(m_lv));
        check_val("overrun", 64'(overrun), 64'(m_ovr));
      end

      if (rst) begin
        q.delete(); m_drw = '0; m_load = 0; m_lv = 0; m_ovr = 0; m_show = 0;
        m_hold = 0; m_ptr = 0; act_q = 0; act_qq = 0;
      end else begin
        if (q.size() == D && |req_valid) m_ovr = 1;
        act_qq = act_q;
        act_q  = (vsync == 1'b0);
        m_load = 0;
        if (flush) begin
          q.delete(); m_drw = '0; m_lv = 0; m_show = 0; m_hold = 0;
        end else begin
          if (pop_ok) begin
            m_drw = q.pop_front();
            m_load = 1; m_lv = 1; m_show = 1; m_hold = H - 1;
          end else if (tick && m_show && m_hold > 0) begin
            m_hold--;
          end
          if (can) begin
            c = 48'(req_cmd >> (48 * gnt));
            q.push_back(c);
            m_ptr = (gnt + 1) % NR;
          end
        end
      end
      model_ok = 1;
      @(posedge clk);
      #1;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
